// File: rtl/mdu_unit_pkg.sv
// -----------------------------------------------------------------------------
// mdu_unit_pkg
// Shared definitions for the E-stage multiply/divide unit: MDUCtrl operation
// encodings, default latencies, counter width and the FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package mdu_unit_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit
// Multiply/divide unit for the E stage. Owns HI/LO. mult/multu/div/divu are
// computed at issue into hold registers and committed to HI/LO after a fixed
// latency (MULT_CYCLES / DIV_CYCLES) while Busy is high. mthi/mtlo write
// HI/LO directly when idle.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset, clears all state
//   MDUEN    in   E-stage instruction is an MDU command
//   MDUCtrl  in   [2:0] operation code (see mdu_unit_pkg)
//   A, B     in   [31:0] forwarded rs / rt operands
//   Start    out  combinational: a long operation issues this cycle
//   Busy     out  registered: long operation in flight
//   HI, LO   out  [31:0] architectural HI/LO registers
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation in flight; accepts any command, Busy=0
// RUN   | counter running down; result waits in hold regs, Busy=1
// -----------------------------------------------------------------------------
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUEN,
    input  logic [2:0]  MDUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       hold_hi;
    logic [31:0]       hold_lo;

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_ovf;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic [CNT_W-1:0]   cnt_load;

    assign Start = MDUEN && is_long_op(MDUCtrl) && !Busy;

    // Low 64 bits of a 64x64 product of sign-extended operands equal the
    // exact 32x32 signed product.
    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Most-negative / -1 overflows; pin the architectural answer explicitly
    // instead of relying on the operator's wrap behaviour.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (B != 32'd0) begin
            if (div_ovf) begin
                quot_s = A;
                rem_s  = '0;
            end else begin
                quot_s = $signed(A) / $signed(B);
                rem_s  = $signed(A) % $signed(B);
            end
            quot_u = A / B;
            rem_u  = A % B;
        end
    end

    // Divide by zero holds the current HI/LO so the commit leaves them as-is.
    always_comb begin
        res_hi   = HI;
        res_lo   = LO;
        cnt_load = CNT_W'(MULT_CYCLES);
        case (MDUCtrl)
            MDU_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_DIV: begin
                cnt_load = CNT_W'(DIV_CYCLES);
                if (B != 32'd0) begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            MDU_DIVU: begin
                cnt_load = CNT_W'(DIV_CYCLES);
                if (B != 32'd0) begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            Busy    <= 1'b0;
            cnt     <= '0;
            hold_hi <= '0;
            hold_lo <= '0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        hold_hi <= res_hi;
                        hold_lo <= res_lo;
                        cnt     <= cnt_load;
                        Busy    <= 1'b1;
                        state   <= ST_RUN;
                    end else if (MDUEN && MDUCtrl == MDU_MTHI) begin
                        HI <= A;
                    end else if (MDUEN && MDUCtrl == MDU_MTLO) begin
                        LO <= A;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        HI    <= hold_hi;
                        LO    <= hold_lo;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit
// Scoreboard bench for mdu_unit. The stimulus process computes expected HI/LO
// and latency with plain 64-bit arithmetic and queues them; a negedge monitor
// pops and compares when the result is due.
// -----------------------------------------------------------------------------
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        MDUEN;
    logic [2:0]  MDUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .MDUEN(MDUEN), .MDUCtrl(MDUCtrl),
        .A(A), .B(B), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          busy_run = 0;
    logic [31:0] vis_hi   = '0;
    logic [31:0] vis_lo   = '0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (Busy) begin
                busy_run++;
                check32("hi_stable_while_busy", HI, vis_hi);
                check32("lo_stable_while_busy", LO, vis_lo);
                check32("protocol_mduen_while_busy", {31'd0, MDUEN}, 32'd0);
            end
            if (sbq.size() > 0 && sbq[0].due == cycle) begin
                mon_e = sbq.pop_front();
                check32("hi_result", HI, mon_e.hi);
                check32("lo_result", LO, mon_e.lo);
                check32("busy_low_at_commit", {31'd0, Busy}, 32'd0);
                check32("busy_length", busy_run, mon_e.len);
                busy_run = 0;
                vis_hi   = mon_e.hi;
                vis_lo   = mon_e.lo;
            end
        end
    end

    // Reference: architectural rules with 64-bit arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] nh, output logic [31:0] nl, output int len);
        longint          ps;
        longint unsigned pu;
        int              da;
        int              db;
        nh  = model_hi;
        nl  = model_lo;
        len = 0;
        case (op)
            MDU_MULT: begin
                ps  = longint'($signed(a)) * longint'($signed(b));
                nh  = ps[63:32];
                nl  = ps[31:0];
                len = MC;
            end
            MDU_MULTU: begin
                pu  = longint'({32'd0, a}) * longint'({32'd0, b});
                nh  = pu[63:32];
                nl  = pu[31:0];
                len = MC;
            end
            MDU_DIV: begin
                len = DC;
                da  = a;
                db  = b;
                if (b == 0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    nl = 32'h8000_0000;
                    nh = 32'd0;
                end else begin
                    nl = da / db;
                    nh = da % db;
                end
            end
            MDU_DIVU: begin
                len = DC;
                if (b != 0) begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            MDU_MTHI: nh = a;
            MDU_MTLO: nl = a;
            default: ;
        endcase
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sbq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (sbq.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] nh;
        logic [31:0] nl;
        int          len;
        @(negedge clk);
        MDUEN   = 1'b1;
        MDUCtrl = op;
        A       = a;
        B       = b;
        #1;
        check32("start", {31'd0, Start}, {31'd0, (op >= 3'd1 && op <= 3'd4)});
        model_op(op, a, b, nh, nl, len);
        @(posedge clk);
        #1;
        MDUEN    = 1'b0;
        MDUCtrl  = 3'($urandom);
        A        = $urandom;
        B        = $urandom;
        model_hi = nh;
        model_lo = nl;
        e.due = cycle + len;
        e.hi  = nh;
        e.lo  = nl;
        e.len = len;
        sbq.push_back(e);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;

        reset   = 1'b1;
        MDUEN   = 1'b0;
        MDUCtrl = MDU_NONE;
        A       = '0;
        B       = '0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_hi", HI, 32'd0);
        check32("reset_lo", LO, 32'd0);
        check32("reset_busy", {31'd0, Busy}, 32'd0);
        check32("reset_start_idle", {31'd0, Start}, 32'd0);
        MDUEN   = 1'b1;
        MDUCtrl = MDU_MULT;
        #1;
        check32("reset_start_follows_inputs", {31'd0, Start}, 32'd1);
        MDUEN = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        issue(MDU_MULT,  32'hFFFF_FFFE, 32'd3);
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
        issue(MDU_DIVU,  32'd7,         32'd2);
        issue(MDU_MTHI,  32'h1234_5678, 32'd0);
        issue(MDU_MTLO,  32'h9ABC_DEF0, 32'd0);
        issue(MDU_MTHI,  32'h0000_00AA, 32'd0);
        issue(MDU_MTLO,  32'h0000_00BB, 32'd0);
        issue(MDU_DIV,   32'd5,         32'd0);
        issue(MDU_DIVU,  32'd9,         32'd0);
        issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(MDU_DIV,   32'd7,         32'hFFFF_FFFE);
        issue(MDU_NONE,  32'h5555_5555, 32'd1);
        issue(3'd7,      32'h6666_6666, 32'd1);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(op, ra, rb);
        end

        issue(MDU_MTHI, 32'hDEAD_0001, 32'd0);
        issue(MDU_MTLO, 32'hBEEF_0002, 32'd0);
        @(negedge clk);
        MDUEN   = 1'b1;
        MDUCtrl = MDU_MULT;
        A       = 32'd3;
        B       = 32'd4;
        @(posedge clk);
        #1;
        MDUEN = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check32("async_reset_busy", {31'd0, Busy}, 32'd0);
        check32("async_reset_hi", HI, 32'd0);
        check32("async_reset_lo", LO, 32'd0);
        sbq.delete();
        busy_run = 0;
        model_hi = '0;
        model_lo = '0;
        vis_hi   = '0;
        vis_lo   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (MC + 3) begin
            @(negedge clk);
            #1;
            check32("post_reset_hi", HI, 32'd0);
            check32("post_reset_lo", LO, 32'd0);
            check32("post_reset_busy", {31'd0, Busy}, 32'd0);
        end

        issue(MDU_MULTU, 32'd6, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage pipelined MIPS core.
- Consumes the decoder's MDUEN/MDUCtrl command pair plus the forwarded E-stage operands, and owns the HI/LO architectural registers.
- Models multi-cycle latency with a Busy handshake. The hazard unit uses Start/Busy to stall D-stage MDU instructions, including MFHI/MFLO.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high after a mult/multu issue (>=1)
DIV_CYCLES, 10, cycles Busy stays high after a div/divu issue (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
MDUEN  input  1  E-stage instruction is an MDU command (mult/multu/div/divu/mthi/mtlo)
MDUCtrl  input  3  operation code, encodings from shared defines
A  input  32  rs operand, forwarded
B  input  32  rt operand, forwarded
Start  output  1  combinational: MDUEN and MDUCtrl is mult/multu/div/divu and unit is idle
Busy  output  1  registered: operation in flight
HI  output  32  HI register, read by MFHI via E-result mux
LO  output  32  LO register, read by MFLO via E-result mux

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - HI=0, LO=0, Busy=0, counter=0; pending result discarded.
  - Start reflects inputs only.
- Encodings:
  - none=0, mult=1, multu=2, div=3, divu=4, mthi=5, mtlo=6; 7 reserved.
  - MDUEN=0 or code 0/7 is a no-op.
- States: IDLE (Busy=0), RUN (Busy=1).
- IDLE, mult/multu/div/divu with MDUEN=1 (Start=1):
  - At that edge: compute the result from A/B into internal hold regs, load counter with N (MULT_CYCLES or DIV_CYCLES), go to RUN.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter==1: HI/LO take the held result, Busy falls, return to IDLE.
  - Timing: issue at edge t0 gives Busy=1 for cycles (t0, t0+N]; HI/LO are visible from t0+N.
- mult: signed 64-bit product; HI=[63:32], LO=[31:0].
- multu: unsigned 64-bit product, same split.
- div:
  - Signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div or divu):
  - Busy sequence runs normally.
  - HI/LO unchanged at completion: held result = current HI/LO captured at issue.
- mthi/mtlo in IDLE:
  - HI<=A or LO<=A at the same edge.
  - No Busy, Start=0.
  - Visible next cycle.
- Commands with MDUEN=1 while Busy=1 (any code):
  - Ignored. The pipeline guarantees this never occurs.
  - Bench flags it as a protocol error.
- Same-edge completion plus new command is impossible (Busy is still 1 that cycle); no special case needed.
- Result computation may be combinational at issue; latency is purely the counter model.

Decomposition:
- Shared defines file holds the MDUCtrl encodings (mduMult, mduMultu, mduDiv, mduDivu, mduMthi, mduMtlo) and default cycle counts.
- Single module; no sub-module is natural. The arithmetic uses Verilog signed/unsigned operators on 64-/32-bit operands.
- Hazard rule lives in the stall unit, not here: stall D if D is an MDU/MFHI/MFLO instruction and (Start or Busy).

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3 -> Start=1 on issue; Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001; HI/LO unchanged while Busy.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0 -> HI/LO update on their own edges; Busy never rises; Start stays 0.
- div A=5, B=0 after HI=0xAA, LO=0xBB -> Busy 10 cycles, then HI=0xAA, LO=0xBB unchanged.
- mult issued, reset pulsed asynchronously mid-cycle at cycle 3 -> Busy, HI and LO drop to 0 immediately; no late write after reset release.
